// File: rtl/bcd_stopwatch_core.sv
// Four-digit BCD stopwatch core. Raw active-low keys are synchronized and edge-detected.
// They drive an IDLE/RUN/PAUSE machine that gates a tick prescaler and a ripple BCD counter.
module bcd_stopwatch_core #(
  parameter int TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start,
  input  logic       key_clear,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       running,
  output logic       wrap
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Returns {carry_out, next_digit}; anything at or above 9 rolls to 0 so digits stay decimal.
  function automatic logic [4:0] bcd_inc(input logic [3:0] digit, input logic cin);
    logic [4:0] res;
    if (!cin) begin
      res = {1'b0, digit};
    end else if (digit >= 4'd9) begin
      res = {1'b1, 4'd0};
    end else begin
      res = {1'b0, digit + 4'd1};
    end
    return res;
  endfunction

  logic          r_start_s1, r_start_s2, r_start_s3;
  logic          r_clear_s1, r_clear_s2, r_clear_s3;
  logic          w_start_press, w_clear_press;
  state_t        r_state, w_next_state;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_d0, r_d1, r_d2, r_d3;
  logic          r_running, r_wrap;
  logic          w_tick;
  logic [4:0]    w_inc0, w_inc1, w_inc2, w_inc3;

  // Key synchronizers; reset to the released level so no press appears out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_s1 <= 1'b1;
      r_start_s2 <= 1'b1;
      r_start_s3 <= 1'b1;
      r_clear_s1 <= 1'b1;
      r_clear_s2 <= 1'b1;
      r_clear_s3 <= 1'b1;
    end else begin
      r_start_s1 <= key_start;
      r_start_s2 <= r_start_s1;
      r_start_s3 <= r_start_s2;
      r_clear_s1 <= key_clear;
      r_clear_s2 <= r_clear_s1;
      r_clear_s3 <= r_clear_s2;
    end
  end

  assign w_start_press = r_start_s3 & ~r_start_s2;
  assign w_clear_press = r_clear_s3 & ~r_clear_s2;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: clear overrides start.
  always_comb begin
    w_next_state = r_state;
    if (w_clear_press) begin
      w_next_state = ST_IDLE;
    end else if (w_start_press) begin
      case (r_state)
        ST_IDLE:  w_next_state = ST_RUN;
        ST_RUN:   w_next_state = ST_PAUSE;
        ST_PAUSE: w_next_state = ST_RUN;
        default:  w_next_state = ST_IDLE;
      endcase
    end else begin
      w_next_state = r_state;
    end
  end

  assign w_tick = (r_state == ST_RUN) && (r_presc == PRESC_MAX);
  assign w_inc0 = bcd_inc(r_d0, w_tick);
  assign w_inc1 = bcd_inc(r_d1, w_inc0[4]);
  assign w_inc2 = bcd_inc(r_d2, w_inc1[4]);
  assign w_inc3 = bcd_inc(r_d3, w_inc2[4]);

  // Prescaler, digits and status outputs; a tick coinciding with a pause still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc   <= PRESC_ZERO;
      r_d0      <= 4'd0;
      r_d1      <= 4'd0;
      r_d2      <= 4'd0;
      r_d3      <= 4'd0;
      r_running <= 1'b0;
      r_wrap    <= 1'b0;
    end else if (w_clear_press) begin
      r_presc   <= PRESC_ZERO;
      r_d0      <= 4'd0;
      r_d1      <= 4'd0;
      r_d2      <= 4'd0;
      r_d3      <= 4'd0;
      r_running <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_d0      <= w_inc0[3:0];
      r_d1      <= w_inc1[3:0];
      r_d2      <= w_inc2[3:0];
      r_d3      <= w_inc3[3:0];
      r_wrap    <= w_inc3[4];
      r_running <= (w_next_state == ST_RUN);
      case (r_state)
        ST_RUN:   r_presc <= w_tick ? PRESC_ZERO : (r_presc + PRESC_ONE);
        ST_PAUSE: r_presc <= r_presc;
        default:  r_presc <= PRESC_ZERO;
      endcase
    end
  end

  assign d0      = r_d0;
  assign d1      = r_d1;
  assign d2      = r_d2;
  assign d3      = r_d3;
  assign running = r_running;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// Bench for bcd_stopwatch_core with TICK_DIV=4. The reference model counts RUN edges and
// derives the displayed value arithmetically; key presses take effect on the third edge after a fall.
module tb_bcd_stopwatch_core;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_start;
  logic       key_clear;
  logic [3:0] d0, d1, d2, d3;
  logic       running, wrap;

  int total = 0;
  int bad = 0;

  int m_e = 0;
  int m_run_edges = 0;
  int m_state = 0;
  bit m_wrap = 1'b0;
  int start_q[$];
  int clear_q[$];

  bcd_stopwatch_core #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .key_start(key_start), .key_clear(key_clear),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic int m_count();
    return (m_run_edges / TD) % 10000;
  endfunction

  function automatic logic [15:0] exp_digits();
    int c;
    c = m_count();
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_run_edges = 0;
    m_wrap = 1'b0;
    start_q.delete();
    clear_q.delete();
  endtask

  task automatic model_step();
    bit s_ev, c_ev;
    m_e++;
    s_ev = 1'b0;
    c_ev = 1'b0;
    while (start_q.size() > 0 && start_q[0] == m_e) begin
      void'(start_q.pop_front());
      s_ev = 1'b1;
    end
    while (clear_q.size() > 0 && clear_q[0] == m_e) begin
      void'(clear_q.pop_front());
      c_ev = 1'b1;
    end
    m_wrap = 1'b0;
    if (m_state == 1) begin
      m_run_edges++;
      m_wrap = (m_run_edges % TD == 0) && (m_count() == 0);
    end
    if (c_ev) begin
      m_state = 0;
      m_run_edges = 0;
      m_wrap = 1'b0;
    end else if (s_ev) begin
      m_state = (m_state == 1) ? 2 : 1;
    end
  endtask

  task automatic advance(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic fall_start();
    key_start = 1'b0;
    start_q.push_back(m_e + 3);
  endtask

  task automatic fall_clear();
    key_clear = 1'b0;
    clear_q.push_back(m_e + 3);
  endtask

  task automatic do_clear_then_start();
    fall_clear();
    advance(2);
    key_clear = 1'b1;
    advance(1);
    fall_start();
    advance(2);
    key_start = 1'b1;
    advance(1);
  endtask

  task automatic test_reset();
    key_start = 1'b1;
    key_clear = 1'b1;
    rst_n = 1'b0;
    #12;
    total++;
    if ({d3, d2, d1, d0} !== 16'h0000) begin
      bad++; $display("FAIL reset_digits got=%h exp=0000", {d3, d2, d1, d0});
    end
    total++;
    if (running !== 1'b0 || wrap !== 1'b0) begin
      bad++; $display("FAIL reset_flags got running=%b wrap=%b exp 0 0", running, wrap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    advance(5);
    total++;
    if (running !== 1'b0 || {d3, d2, d1, d0} !== 16'h0000) begin
      bad++; $display("FAIL reset_idle_hold got running=%b digits=%h exp 0 0000", running, {d3, d2, d1, d0});
    end
  endtask

  task automatic test_start_latency();
    fall_start();
    advance(1);
    total++;
    if (running !== 1'b0) begin bad++; $display("FAIL start_edge1 got=%b exp=0", running); end
    advance(1);
    total++;
    if (running !== 1'b0) begin bad++; $display("FAIL start_edge2 got=%b exp=0", running); end
    key_start = 1'b1;
    advance(1);
    total++;
    if (running !== 1'b1) begin bad++; $display("FAIL start_edge3 got=%b exp=1", running); end
    advance(3);
    total++;
    if ({d3, d2, d1, d0} !== 16'h0000) begin
      bad++; $display("FAIL first_tick_early got=%h exp=0000", {d3, d2, d1, d0});
    end
    advance(1);
    total++;
    if ({d3, d2, d1, d0} !== 16'h0001) begin
      bad++; $display("FAIL first_tick got=%h exp=0001", {d3, d2, d1, d0});
    end
    advance(20);
    total++;
    if (running !== 1'b1 || {d3, d2, d1, d0} !== exp_digits()) begin
      bad++; $display("FAIL single_press got running=%b digits=%h exp 1 %h", running, {d3, d2, d1, d0}, exp_digits());
    end
  endtask

  task automatic test_run_count();
    int guard;
    guard = 0;
    while (m_count() < 40 && guard < 1000) begin
      advance(1);
      guard++;
      total++;
      if ({d3, d2, d1, d0} !== exp_digits()) begin
        bad++; $display("FAIL run_step got=%h exp=%h", {d3, d2, d1, d0}, exp_digits());
      end
      if (m_count() == 10 && m_run_edges % TD == 0) begin
        total++;
        if ({d1, d0} !== 8'h10) begin bad++; $display("FAIL carry_0010 got=%h exp=10", {d1, d0}); end
      end
    end
    total++;
    if ({d3, d2, d1, d0} !== 16'h0040) begin
      bad++; $display("FAIL run_40 got=%h exp=0040", {d3, d2, d1, d0});
    end
  endtask

  task automatic test_pause_freeze();
    int guard;
    int pause_count;
    logic [15:0] frozen;
    advance($urandom_range(0, 7));
    guard = 0;
    while (m_run_edges % TD != TD - 1 && guard < 10) begin advance(1); guard++; end
    fall_start();
    advance(2);
    key_start = 1'b1;
    advance(1);
    total++;
    if (running !== 1'b0) begin bad++; $display("FAIL pause_enter got=%b exp=0", running); end
    pause_count = m_count();
    frozen = exp_digits();
    for (int i = 0; i < 50; i++) begin
      advance(1);
      total++;
      if ({d3, d2, d1, d0} !== frozen) begin
        bad++; $display("FAIL pause_hold got=%h exp=%h", {d3, d2, d1, d0}, frozen);
      end
    end
    fall_start();
    advance(2);
    key_start = 1'b1;
    advance(1);
    total++;
    if (running !== 1'b1) begin bad++; $display("FAIL resume got=%b exp=1", running); end
    advance(1);
    total++;
    if ({d3, d2, d1, d0} !== frozen) begin
      bad++; $display("FAIL resume_early got=%h exp=%h", {d3, d2, d1, d0}, frozen);
    end
    advance(1);
    total++;
    if ({d3, d2, d1, d0} !== exp_digits() || m_count() != pause_count + 1) begin
      bad++; $display("FAIL resume_tick got=%h exp=%h", {d3, d2, d1, d0}, exp_digits());
    end
  endtask

  task automatic test_clear_start();
    int guard;
    guard = 0;
    while (m_run_edges < 123 * TD && guard < 1000) begin advance(1); guard++; end
    total++;
    if (m_run_edges != 123 * TD) begin bad++; $display("FAIL clr_reach got=%0d exp=%0d", m_run_edges, 123 * TD); end
    fall_start();
    fall_clear();
    advance(2);
    key_start = 1'b1;
    key_clear = 1'b1;
    total++;
    if ({d3, d2, d1, d0} !== 16'h0123) begin
      bad++; $display("FAIL clr_pre got=%h exp=0123", {d3, d2, d1, d0});
    end
    advance(1);
    total++;
    if ({d3, d2, d1, d0} !== 16'h0000 || running !== 1'b0 || wrap !== 1'b0) begin
      bad++; $display("FAIL clr_wins got digits=%h running=%b wrap=%b exp 0000 0 0", {d3, d2, d1, d0}, running, wrap);
    end
    advance(10);
    total++;
    if ({d3, d2, d1, d0} !== 16'h0000 || running !== 1'b0) begin
      bad++; $display("FAIL clr_idle got digits=%h running=%b exp 0000 0", {d3, d2, d1, d0}, running);
    end
    fall_start();
    advance(2);
    key_start = 1'b1;
    advance(4);
    total++;
    if ({d3, d2, d1, d0} !== 16'h0000) begin
      bad++; $display("FAIL clr_presc0_early got=%h exp=0000", {d3, d2, d1, d0});
    end
    advance(1);
    total++;
    if ({d3, d2, d1, d0} !== 16'h0001) begin
      bad++; $display("FAIL clr_presc0 got=%h exp=0001", {d3, d2, d1, d0});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (key_start == 1'b1) begin
        if ($urandom_range(0, 11) == 0) fall_start();
      end else if ($urandom_range(0, 1) == 0) begin
        key_start = 1'b1;
      end
      if (key_clear == 1'b1) begin
        if ($urandom_range(0, 59) == 0) fall_clear();
      end else begin
        key_clear = 1'b1;
      end
      advance(1);
      total++;
      if ({d3, d2, d1, d0} !== exp_digits() || running !== (m_state == 1) || wrap !== m_wrap) begin
        bad++;
        $display("FAIL random got digits=%h running=%b wrap=%b exp %h %b %b",
                 {d3, d2, d1, d0}, running, wrap, exp_digits(), (m_state == 1), m_wrap);
      end
    end
    key_start = 1'b1;
    key_clear = 1'b1;
    advance(5);
  endtask

  task automatic test_wrap();
    int guard;
    do_clear_then_start();
    guard = 0;
    while (m_count() < 9998 && guard < 50000) begin advance(1); guard++; end
    total++;
    if ({d3, d2, d1, d0} !== 16'h9998) begin
      bad++; $display("FAIL wrap_preload got=%h exp=9998", {d3, d2, d1, d0});
    end
    advance(TD);
    total++;
    if ({d3, d2, d1, d0} !== 16'h9999 || wrap !== 1'b0) begin
      bad++; $display("FAIL wrap_9999 got=%h wrap=%b exp 9999 0", {d3, d2, d1, d0}, wrap);
    end
    advance(TD - 1);
    total++;
    if ({d3, d2, d1, d0} !== 16'h9999 || wrap !== 1'b0) begin
      bad++; $display("FAIL wrap_before got=%h wrap=%b exp 9999 0", {d3, d2, d1, d0}, wrap);
    end
    advance(1);
    total++;
    if ({d3, d2, d1, d0} !== 16'h0000 || wrap !== 1'b1 || running !== 1'b1) begin
      bad++; $display("FAIL wrap_edge got digits=%h wrap=%b running=%b exp 0000 1 1", {d3, d2, d1, d0}, wrap, running);
    end
    advance(1);
    total++;
    if (wrap !== 1'b0 || running !== 1'b1) begin
      bad++; $display("FAIL wrap_pulse got wrap=%b running=%b exp 0 1", wrap, running);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    do_clear_then_start();
    guard = 0;
    while (m_count() < 567 && guard < 5000) begin advance(1); guard++; end
    advance(1);
    total++;
    if ({d3, d2, d1, d0} !== 16'h0567) begin
      bad++; $display("FAIL mid_preload got=%h exp=0567", {d3, d2, d1, d0});
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({d3, d2, d1, d0} !== 16'h0000 || running !== 1'b0 || wrap !== 1'b0) begin
      bad++; $display("FAIL mid_reset got digits=%h running=%b wrap=%b exp 0000 0 0", {d3, d2, d1, d0}, running, wrap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    advance(20);
    total++;
    if ({d3, d2, d1, d0} !== 16'h0000 || running !== 1'b0 || wrap !== 1'b0) begin
      bad++; $display("FAIL mid_idle got digits=%h running=%b wrap=%b exp 0000 0 0", {d3, d2, d1, d0}, running, wrap);
    end
    fall_start();
    advance(2);
    key_start = 1'b1;
    advance(1);
    total++;
    if (running !== 1'b1) begin bad++; $display("FAIL mid_restart got=%b exp=1", running); end
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_run_count();
    test_pause_freeze();
    test_clear_start();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
